// File: rtl/mult_div_unit.sv
// Purpose: iterative signed/unsigned multiply (shift-add) and divide (restoring), hi/lo result pair.
// Latency: WIDTH+2 edges from start sample to done for mul/div; 1 edge for divide by zero.
// Backpressure: none; start is only sampled in IDLE, and is ignored while busy or in DONE.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;       // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   mag_b_q;     // multiplicand or divisor magnitude
   logic               is_div_q;
   logic               neg_q;       // negate product / quotient in FIX
   logic               neg_rem_q;   // remainder follows the dividend sign
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;
   logic               div_zero_q;

   // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits unsigned WIDTH bits.
   logic               signed_op;
   logic [WIDTH-1:0]   mag_a_d;
   logic [WIDTH-1:0]   mag_b_d;
   logic               last_iter;

   // One shift-add step.
   logic [WIDTH:0]     mul_sum_d;
   logic [2*WIDTH-1:0] mul_next_d;

   // One restoring-division step.
   logic [WIDTH:0]     div_shift_d;
   logic [WIDTH:0]     div_diff_d;
   logic               div_ge_d;
   logic [2*WIDTH-1:0] div_next_d;

   // Sign-corrected result.
   logic [WIDTH-1:0]   quo_fix_d;
   logic [WIDTH-1:0]   rem_fix_d;
   logic [2*WIDTH-1:0] fix_d;

   // Operand magnitude extraction at the point start is sampled
   always_comb begin
      signed_op = ~op[0];
      mag_a_d   = (signed_op && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
      mag_b_d   = (signed_op && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
      last_iter = (cnt_q == CW'(WIDTH - 1));
   end

   // Shift-add: add multiplicand to upper half when multiplier LSB is set, then shift right
   always_comb begin
      mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
      mul_next_d = {mul_sum_d, acc_q[WIDTH-1:1]};
   end

   // Restoring divide: shift in next dividend bit, subtract divisor if it fits
   always_comb begin
      div_shift_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff_d  = div_shift_d - {1'b0, mag_b_q};
      div_ge_d    = (div_shift_d >= {1'b0, mag_b_q});
      if (div_ge_d) begin
         div_next_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next_d = {div_shift_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction; the neg flags are only ever set for signed ops so unsigned passes through
   always_comb begin
      quo_fix_d = neg_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      rem_fix_d = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         fix_d = {rem_fix_d, quo_fix_d};
      end else begin
         fix_d = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mag_b_q    <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  // Low half holds multiplier or dividend; both ops start from the same layout.
                  acc_q     <= {{WIDTH{1'b0}}, mag_a_d};
                  mag_b_q   <= mag_b_d;
                  is_div_q  <= op[1];
                  neg_q     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_q <= signed_op & a[WIDTH-1];
                  if (op[1] && (b == '0)) begin
                     div_zero_q <= 1'b1;
                     state_q    <= S_DONE;
                  end else begin
                     div_zero_q <= 1'b0;
                     state_q    <= op[1] ? S_DIV : S_MUL;
                  end
               end
            end
            S_MUL: begin
               acc_q <= mul_next_d;
               if (last_iter) begin
                  cnt_q   <= '0;
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DIV: begin
               acc_q <= div_next_d;
               if (last_iter) begin
                  cnt_q   <= '0;
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_FIX: begin
               acc_q   <= fix_d;
               state_q <= S_DONE;
            end
            S_DONE: begin
               // A divide by zero leaves the previous result visible.
               if (!div_zero_q) begin
                  hi_q <= acc_q[2*WIDTH-1:WIDTH];
                  lo_q <= acc_q[WIDTH-1:0];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level reference model plus directed vectors with literal results.
// Latency: model tracks acceptance and completion edges independently of the design's state machine.
// Backpressure: stimulus re-pulses start while busy and in the completion cycle to confirm it is dropped.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a, b;
   logic [W-1:0]  hi, lo;
   logic          busy, done, div_zero;

   logic          start8;
   logic [1:0]    op8;
   logic [7:0]    a8, b8;
   logic [7:0]    hi8, lo8;
   logic          busy8, done8, dz8;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic          m_busy, m_done, m_dz;
   logic [W-1:0]  m_hi, m_lo;
   logic [63:0]   m_pend;
   int            m_left;
   bit            cmp_en = 1'b0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   mult_div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: {hi,lo} for a non-zero-divisor op
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00:   return 64'(sx * sy);
         2'b01:   return {32'b0, x} * {32'b0, y};
         2'b10: begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: return {x % y, x / y};
      endcase
   endfunction

   // Model: accept start when idle, complete after the fixed latency
   initial begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_pend = '0; m_left = 0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_left = 0;
         end else begin
            m_done = 0;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1;
                  m_busy = 0;
                  if (!m_dz) {m_hi, m_lo} = m_pend;
               end
            end else if (start) begin
               m_busy = 1;
               m_dz   = op[1] && (b == '0);
               m_left = m_dz ? 1 : W + 2;
               if (!m_dz) m_pend = ref_result(op, a, b);
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc div_zero", div_zero, m_dz);
            chk("cyc hi", hi, m_hi);
            chk("cyc lo", lo, m_lo);
         end
      end
   end

   task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int elat,
                        input bit rel_rst);
      int n;
      @(negedge clk);
      if (rel_rst) reset = 1'b1;
      start = 1'b1; op = o; a = xa; b = xb;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      chk({name, " latency"}, n, elat);
      chk({name, " hi"}, hi, ehi);
      chk({name, " lo"}, lo, elo);
      chk({name, " div_zero"}, div_zero, edz);
   endtask

   initial begin
      int dones;
      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset div_zero", div_zero, 0);
      chk("reset hi", hi, 0);
      chk("reset lo", lo, 0);
      cmp_en = 1'b1;

      // First start lands on the first edge after reset release
      do_op("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, 1'b1);
      do_op("multu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b0);
      do_op("mult minneg^2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 1'b0);
      do_op("mult 7*-6", 2'b00, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 34, 1'b0);
      do_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
      do_op("div 100/-7", 2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 34, 1'b0);
      do_op("divu max/16", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 34, 1'b0);
      do_op("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34, 1'b0);
      do_op("divu 7/0", 2'b11, 32'd7, 32'd0, 32'd1, 32'd3, 1'b1, 1, 1'b0);
      do_op("div minneg/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 1'b0);

      // start re-pulsed while busy and in the completion cycle must be dropped
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
      @(posedge clk);
      dones = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = ((k >= 5) && (k <= 7)) || (k == 34);
         op = 2'b00; a = 32'h1234; b = 32'h55;
         @(posedge clk);
         #1;
         if (done) begin
            dones++;
            chk("ignore latency", k, 34);
            chk("ignore hi", hi, 32'd2);
            chk("ignore lo", lo, 32'd14);
         end
      end
      chk("ignore done count", dones, 1);
      chk("ignore idle after", busy, 0);

      // Reset during a multiply aborts it without a done
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort hi", hi, 0);
      chk("abort lo", lo, 0);
      chk("abort done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("abort no done", dones, 0);

      // Narrow instance
      @(negedge clk);
      start8 = 1'b1; op8 = 2'b00; a8 = 8'hFD; b8 = 8'd5;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         dones++;
         #1;
         if (done8) break;
      end
      chk("w8 mult latency", dones, 10);
      chk("w8 mult hi", hi8, 8'hFF);
      chk("w8 mult lo", lo8, 8'hF1);

      @(negedge clk);
      start8 = 1'b1; op8 = 2'b10; a8 = 8'hF9; b8 = 8'd2;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         dones++;
         #1;
         if (done8) break;
      end
      chk("w8 div latency", dones, 10);
      chk("w8 div hi", hi8, 8'hFF);
      chk("w8 div lo", lo8, 8'hFD);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits, operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: multiplicand/multiplier, or dividend/divisor.
REQ-007 The block SHALL have ports hi and lo, output, WIDTH bits each; product is {hi,lo}, and for division lo = quotient and hi = remainder.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse on completion.
REQ-010 The block SHALL have port div_zero, output, 1 bit, held high after a divide by zero until the next accepted start.

Function
REQ-011 The FSM SHALL have the states IDLE, MUL, DIV, FIX and DONE.
REQ-012 In IDLE, with start=1, the block SHALL latch op, a and b, clear div_zero and assert busy on the next cycle.
REQ-013 From IDLE with start=1, the next state SHALL be MUL for op[1]=0, DIV for op[1]=1 with b!=0, and DONE for op[1]=1 with b=0.
REQ-014 MUL SHALL run an iterative shift-add over operand magnitudes, one bit per cycle, for exactly WIDTH cycles, counted by an internal counter of clog2(WIDTH)+1 bits.
REQ-015 DIV SHALL run a restoring division over operand magnitudes, one quotient bit per cycle, for exactly WIDTH cycles.
REQ-016 FIX SHALL last 1 cycle and apply sign correction for signed ops: product negated if sign(a) XOR sign(b); quotient negated if sign(a) XOR sign(b); remainder takes the sign of the dividend.
REQ-017 Signed division SHALL truncate toward zero.
REQ-018 For unsigned ops, FIX SHALL pass values through unchanged.
REQ-019 In DONE, hi and lo SHALL update from the result, done SHALL be 1 for exactly one cycle, busy SHALL drop, and the next state SHALL be IDLE.
REQ-020 Latency SHALL be fixed: for a non-zero-divisor op, done is high in the cycle after the (WIDTH+2)th rising edge following the edge that samples start (34 edges for WIDTH=32).
REQ-021 Divide by zero SHALL go straight to DONE: done pulses on the 2nd cycle after start is sampled, div_zero=1, and hi/lo keep their previous values.
REQ-022 Signed DIV of most-negative by -1 SHALL wrap: lo = most-negative value, hi = 0, with no flag.
REQ-023 The most-negative magnitude SHALL be handled with a WIDTH+1-bit internal magnitude or an equivalent, so that MULT of most-negative by most-negative is exact.
REQ-024 start SHALL be ignored while busy=1 or in DONE; a and b may change after the sampling edge without effect.
REQ-025 start asserted in the same cycle DONE returns to IDLE SHALL NOT be accepted; it is accepted only once the state is IDLE.
REQ-026 hi and lo SHALL hold their value between completions and change only in DONE.
REQ-027 Ops are back-to-back capable: the minimum start-to-start spacing SHALL be WIDTH+3 cycles.

Reset
REQ-028 When reset=0, the block SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0 and clear the counter and internal registers.
REQ-029 Reset asserted mid-operation SHALL abort that operation, and no done SHALL be produced for it.
REQ-030 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-031 Bench SHALL cover MULT: a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done exactly 34 edges after start, busy high throughout.
REQ-032 Bench SHALL cover MULTU: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; and MULT with a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-033 Bench SHALL cover DIV: a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU with a=7, b=2 -> lo=3, hi=1.
REQ-034 Bench SHALL cover DIVU: a=7, b=0 after a prior result of hi=1, lo=3 -> done on 2nd cycle, div_zero=1, hi=1, lo=3 unchanged.
REQ-035 Bench SHALL cover DIV: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-036 Bench SHALL cover three cases: start re-pulsed with a new op while busy -> ignored, first result unchanged; reset=0 at cycle 10 of a MULT -> busy=0, hi=lo=0, no done; rerun at WIDTH=8 with a=-3, b=5 -> hi=0xFF, lo=0xF1 after 10 edges.
